ret_stack_mt: RTL and testbench

//   Parametrised multi-thread return-address stack for the fetch front end.

---
 rtl/ret_stack_mt.sv | 146 ++++++++++++++
 tb/tb_ret_stack_mt.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ret_stack_mt.sv
// ret_stack_mt: multi-thread return-address stack for the fetch front end.
// Calls push a link-adjusted return target; returns pop the top entry.
// Each thread has its own top-of-stack pointer and occupancy counter, and
// its own row block in one shared RAM, addressed {thread, ptr}.
// Optional feature macro: RSTACK_CKPT_EN adds pointer checkpoint/restore
// for mispredict repair (ckpt/restore/restore_thread/restore_ckpt ports).
module ret_stack_mt #(
  parameter int DATA_WIDTH = 67,
  parameter int DEPTH      = 16,
  parameter int THREADS    = 2,
  localparam int TID_W     = (THREADS > 1) ? $clog2(THREADS) : 1,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TID_W-1:0]       thread,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic [4:0]             push_lnk,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  pop_data,
  output logic                   pop_valid,
  output logic [CNT_W-1:0]       count,
`ifdef RSTACK_CKPT_EN
  output logic [PTR_W+CNT_W-1:0] ckpt,
  input  logic                   restore,
  input  logic [TID_W-1:0]       restore_thread,
  input  logic [PTR_W+CNT_W-1:0] restore_ckpt,
`endif
  input  logic                   except,
  input  logic [TID_W-1:0]       except_thread
);

  localparam int AW   = TID_W + PTR_W;
  localparam int NENT = THREADS * DEPTH;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] TOS_RST  = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]      tos_q [THREADS];
  logic [CNT_W-1:0]      cnt_q [THREADS];
  logic [PTR_W-1:0]      tos_d [THREADS];
  logic [CNT_W-1:0]      cnt_d [THREADS];
  logic [DATA_WIDTH-1:0] mem_q [NENT];

  logic [DATA_WIDTH-1:0] entry;
  logic                  tid_ok, ex_hit, rs_hit, op_ok, do_push, do_pop;
  logic [PTR_W-1:0]      cur_tos;
  logic [CNT_W-1:0]      cur_cnt;
  logic [AW-1:0]         rd_addr, wr_addr;
  logic                  pop_valid_d;

  // Thread ids beyond THREADS (non power-of-two counts) never touch state.
  assign tid_ok  = (int'(thread) < THREADS);
  assign cur_tos = tid_ok ? tos_q[thread] : '0;
  assign cur_cnt = tid_ok ? cnt_q[thread] : '0;
  assign count   = cur_cnt;

`ifdef RSTACK_CKPT_EN
  assign ckpt   = {cur_tos, cur_cnt};
  assign rs_hit = restore && (restore_thread == thread);
`else
  assign rs_hit = 1'b0;
`endif

  // A flush or pointer reload of the addressed thread drops its push/pop.
  assign ex_hit  = except && (except_thread == thread);
  assign op_ok   = tid_ok && !ex_hit && !rs_hit;
  assign do_push = push && op_ok;
  assign do_pop  = pop && op_ok;

  // Push+pop replaces the top slot; a plain push writes one above it.
  assign rd_addr = {thread, cur_tos};
  assign wr_addr = do_pop ? {thread, cur_tos} : {thread, PTR_W'(cur_tos + 1'b1)};

  assign pop_valid_d = do_pop && (cur_cnt != '0);

  // Link adjustment: bump the target field by lnk[4], low nibble from lnk[3:0].
  always_comb begin
    entry        = push_data;
    entry[46:4]  = push_data[46:4] + 43'(push_lnk[4]);
    entry[3:0]   = push_lnk[3:0];
  end

  // Per-thread pointer/occupancy next state; except overrides restore overrides ops.
  always_comb begin
    for (int t = 0; t < THREADS; t++) begin
      tos_d[t] = tos_q[t];
      cnt_d[t] = cnt_q[t];
      if (thread == TID_W'(t)) begin
        if (do_push && do_pop) begin
          if (cnt_q[t] == '0) cnt_d[t] = CNT_W'(1);
        end else if (do_push) begin
          tos_d[t] = tos_q[t] + 1'b1;
          if (cnt_q[t] != CNT_FULL) cnt_d[t] = cnt_q[t] + 1'b1;
        end else if (do_pop) begin
          tos_d[t] = tos_q[t] - 1'b1;
          if (cnt_q[t] != '0) cnt_d[t] = cnt_q[t] - 1'b1;
        end
      end
`ifdef RSTACK_CKPT_EN
      if (restore && (restore_thread == TID_W'(t))) begin
        tos_d[t] = restore_ckpt[CNT_W +: PTR_W];
        cnt_d[t] = restore_ckpt[CNT_W-1:0];
      end
`endif
      if (except && (except_thread == TID_W'(t))) begin
        tos_d[t] = TOS_RST;
        cnt_d[t] = '0;
      end
    end
  end

  // Per-thread pointer/occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < THREADS; t++) begin
        tos_q[t] <= TOS_RST;
        cnt_q[t] <= '0;
      end
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        tos_q[t] <= tos_d[t];
        cnt_q[t] <= cnt_d[t];
      end
    end
  end

  // Registered pop result; the RAM read is combinational so a push from the
  // previous cycle is already in the array and needs no bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      pop_valid <= pop_valid_d;
      if (do_pop) pop_data <= mem_q[rd_addr];
    end
  end

  // Entry RAM write; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_addr] <= entry;
  end

endmodule

// File: tb/tb_ret_stack_mt.sv
// Bench for ret_stack_mt: table of per-cycle vectors with a pop-result
// scoreboard, plus hand-written reset and checkpoint sequences.
module tb_ret_stack_mt;
  localparam int DW = 67, DEPTH = 16, TID_W = 1, PTR_W = 4, CNT_W = 5;

  logic              clk, rst;
  logic [TID_W-1:0]  thread, except_thread;
  logic              push, pop, except;
  logic [DW-1:0]     push_data, pop_data;
  logic [4:0]        push_lnk;
  logic              pop_valid;
  logic [CNT_W-1:0]  count;
`ifdef RSTACK_CKPT_EN
  logic [PTR_W+CNT_W-1:0] ckpt, restore_ckpt, cap;
  logic                   restore;
  logic [TID_W-1:0]       restore_thread;
`endif

  ret_stack_mt dut (
    .clk(clk), .rst(rst), .thread(thread), .push(push), .push_data(push_data),
    .push_lnk(push_lnk), .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
    .count(count),
`ifdef RSTACK_CKPT_EN
    .ckpt(ckpt), .restore(restore), .restore_thread(restore_thread),
    .restore_ckpt(restore_ckpt),
`endif
    .except(except), .except_thread(except_thread)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TID_W-1:0] thr;
    logic             pu;
    logic [DW-1:0]    d;
    logic [4:0]       l;
    logic             po;
    logic             ex;
    logic [TID_W-1:0] ext;
    int               c;    // expected count of thr before the edge
    logic             pv;   // expected pop_valid after the edge
    logic             cd;   // compare pop_data
    logic [DW-1:0]    ed;
  } vec_t;

  typedef struct {
    logic          pv;
    logic          cd;
    logic [DW-1:0] d;
    int            id;
  } sb_t;

  vec_t vt[$];
  sb_t  sb[$];
  int   checks = 0, failures = 0;

  function automatic logic [DW-1:0] ent(logic [DW-1:0] d, logic [4:0] l);
    logic [DW-1:0] r;
    r       = d;
    r[46:4] = d[46:4] + {42'b0, l[4]};
    r[3:0]  = l[3:0];
    return r;
  endfunction

  function automatic vec_t mkv(int thr, bit pu, logic [DW-1:0] d, logic [4:0] l, bit po,
                               bit ex, int ext, int c, bit pv, bit cd, logic [DW-1:0] ed);
    vec_t r;
    r.thr = TID_W'(thr); r.pu = pu; r.d = d; r.l = l; r.po = po;
    r.ex = ex; r.ext = TID_W'(ext); r.c = c; r.pv = pv; r.cd = cd; r.ed = ed;
    return r;
  endfunction

  function automatic vec_t idle(int thr, int c);
    return mkv(thr, 0, '0, '0, 0, 0, 0, c, 0, 0, '0);
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out();
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("v%0d pop_valid", e.id), DW'(pop_valid), DW'(e.pv));
      if (e.cd) chk($sformatf("v%0d pop_data", e.id), pop_data, e.d);
    end
  endtask

  task automatic drive_idle();
    thread = '0; push = 1'b0; push_data = '0; push_lnk = '0; pop = 1'b0;
    except = 1'b0; except_thread = '0;
  endtask

  task automatic cyc(vec_t v, int id);
    @(negedge clk);
    check_out();
    thread = v.thr; push = v.pu; push_data = v.d; push_lnk = v.l; pop = v.po;
    except = v.ex; except_thread = v.ext;
    #1;
    chk($sformatf("v%0d count", id), DW'(count), DW'(v.c));
    sb.push_back('{pv: v.pv, cd: v.cd, d: v.ed, id: id});
  endtask

  initial begin
    logic [DW-1:0] a, b, c, w, x, y, z, e3;
    rst = 1'b1;
    drive_idle();
`ifdef RSTACK_CKPT_EN
    restore = 1'b0; restore_thread = '0; restore_ckpt = '0; cap = '0;
`endif
    a = 67'h4_0000_0A00; b = 67'h1_2345_6780; c = 67'h7_FFFF_FFF0;
    w = 67'h0_0000_1110; x = 67'h0_0000_2220; y = 67'h0_0000_3330;
    z = 67'h5_5555_5550; e3 = 67'h0_0000_0990;

    // 1: push then pop, link increment and low field
    vt.push_back(mkv(0, 1, 67'h10, 5'h13, 0, 0, 0, 0, 0, 0, '0));
    vt.push_back(mkv(0, 0, '0, '0, 1, 0, 0, 1, 1, 1, 67'h23));
    vt.push_back(idle(0, 0));
    // 2: LIFO order, then underflow
    vt.push_back(mkv(0, 1, a, 5'h01, 0, 0, 0, 0, 0, 0, '0));
    vt.push_back(mkv(0, 1, b, 5'h1F, 0, 0, 0, 1, 0, 0, '0));
    vt.push_back(mkv(0, 1, c, 5'h10, 0, 0, 0, 2, 0, 0, '0));
    vt.push_back(mkv(0, 0, '0, '0, 1, 0, 0, 3, 1, 1, ent(c, 5'h10)));
    vt.push_back(mkv(0, 0, '0, '0, 1, 0, 0, 2, 1, 1, ent(b, 5'h1F)));
    vt.push_back(mkv(0, 0, '0, '0, 1, 0, 0, 1, 1, 1, ent(a, 5'h01)));
    vt.push_back(mkv(0, 0, '0, '0, 1, 0, 0, 0, 0, 0, '0));
    vt.push_back(idle(0, 0));
    // 3: overflow on thread 1, count saturates, newest DEPTH survive
    for (int i = 0; i < DEPTH + 2; i++)
      vt.push_back(mkv(1, 1, DW'(i) << 8, 5'h02, 0, 0, 0, (i < DEPTH) ? i : DEPTH, 0, 0, '0));
    for (int j = 0; j < DEPTH + 2; j++) begin
      if (j < DEPTH)
        vt.push_back(mkv(1, 0, '0, '0, 1, 0, 0, DEPTH - j, 1, 1,
                         ent(DW'(DEPTH + 1 - j) << 8, 5'h02)));
      else
        vt.push_back(mkv(1, 0, '0, '0, 1, 0, 0, 0, 0, 0, '0));
    end
    vt.push_back(idle(1, 0));
    // 4: push+pop replaces top
    vt.push_back(mkv(0, 1, w, 5'h04, 0, 0, 0, 0, 0, 0, '0));
    vt.push_back(mkv(0, 1, x, 5'h05, 0, 0, 0, 1, 0, 0, '0));
    vt.push_back(mkv(0, 1, y, 5'h06, 1, 0, 0, 2, 1, 1, ent(x, 5'h05)));
    vt.push_back(mkv(0, 0, '0, '0, 1, 0, 0, 2, 1, 1, ent(y, 5'h06)));
    vt.push_back(mkv(0, 0, '0, '0, 1, 0, 0, 1, 1, 1, ent(w, 5'h04)));
    vt.push_back(idle(0, 0));
    // 5: except on thread 0 while thread 1 pushes
    vt.push_back(mkv(0, 1, a, 5'h00, 0, 0, 0, 0, 0, 0, '0));
    vt.push_back(mkv(0, 1, b, 5'h00, 0, 0, 0, 1, 0, 0, '0));
    vt.push_back(mkv(0, 1, c, 5'h00, 0, 0, 0, 2, 0, 0, '0));
    vt.push_back(mkv(1, 1, z, 5'h17, 0, 1, 0, 0, 0, 0, '0));
    vt.push_back(idle(0, 0));
    vt.push_back(mkv(1, 0, '0, '0, 1, 0, 0, 1, 1, 1, ent(z, 5'h17)));
    vt.push_back(idle(1, 0));
    // except drops a same-thread pop and push
    vt.push_back(mkv(0, 1, e3, 5'h08, 0, 0, 0, 0, 0, 0, '0));
    vt.push_back(mkv(0, 0, '0, '0, 1, 1, 0, 1, 0, 0, '0));
    vt.push_back(mkv(0, 1, e3, 5'h08, 0, 1, 0, 0, 0, 0, '0));
    vt.push_back(mkv(0, 0, '0, '0, 1, 0, 0, 0, 0, 0, '0));
    vt.push_back(idle(0, 0));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset pop_valid", DW'(pop_valid), '0);
    chk("reset pop_data", pop_data, '0);
    chk("reset count", DW'(count), '0);
    rst = 1'b0;

    foreach (vt[i]) cyc(vt[i], i);
    @(negedge clk);
    check_out();
    drive_idle();

    // reset in the middle of a popped result clears it asynchronously
    @(negedge clk);
    push = 1'b1; push_data = a; push_lnk = 5'h1;
    @(negedge clk);
    push = 1'b0; pop = 1'b1;
    @(posedge clk);
    #1;
    pop = 1'b0;
    chk("pre-reset pop_valid", DW'(pop_valid), DW'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("async reset pop_valid", DW'(pop_valid), '0);
    chk("async reset pop_data", pop_data, '0);
    chk("async reset count", DW'(count), '0);
    @(negedge clk);
    rst = 1'b0;

`ifdef RSTACK_CKPT_EN
    // checkpoint at count 2, push twice, pop once, restore
    @(negedge clk); push = 1'b1; push_data = x; push_lnk = 5'h03;
    @(negedge clk); push_data = y; push_lnk = 5'h04;
    @(negedge clk); push = 1'b0;
    #1;
    cap = ckpt;
    chk("ckpt capture", DW'(cap), DW'({4'd1, 5'd2}));
    @(negedge clk); push = 1'b1; push_data = z;
    @(negedge clk); push_data = w;
    @(negedge clk); push = 1'b0; pop = 1'b1;
    @(negedge clk); pop = 1'b0; restore = 1'b1; restore_thread = '0; restore_ckpt = cap;
    @(negedge clk); restore = 1'b0;
    #1;
    chk("restore count", DW'(count), DW'(2));
    chk("restore ckpt", DW'(ckpt), DW'(cap));
    @(negedge clk); pop = 1'b1;
    @(negedge clk); pop = 1'b0;
    chk("restore pop_valid", DW'(pop_valid), DW'(1));
    chk("restore pop_data", pop_data, ent(y, 5'h04));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
